// File: rtl/load_store_unit.sv
// load_store_unit: EX/MEM load/store engine with a single-beat dmem bus.
// Optional build macro MISALIGN_TRAP_EN adds the misaligned trap output.
module load_store_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  ctrl_mem_read,
    input  logic                  ctrl_mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] mem_result,
    output logic [DATA_WIDTH-1:0] from_mem,
    output logic                  stall,
`ifdef MISALIGN_TRAP_EN
    output logic                  misaligned,
`endif
    output logic                  bus_error
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic                  is_mem;
    logic                  accept;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;
    logic [DATA_WIDTH-1:0] load_val;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
`ifdef MISALIGN_TRAP_EN
    logic                  mis;
`endif

    assign is_mem = ctrl_mem_read | ctrl_mem_write;
    assign accept = (state == IDLE) & i_valid & is_mem;
    assign stall  = accept | (state == BUS);

`ifdef MISALIGN_TRAP_EN
    assign mis = ((funct3[1:0] == 2'b01) & alu_result[0])
               | (funct3[1] & (|alu_result[1:0]));
`endif

    // Byte enables and lane-replicated store data for the incoming op
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = write_data;
        unique case (1'b1)
            (funct3[1:0] == 2'b00): begin
                be_calc    = 4'b0001 << alu_result[1:0];
                wdata_calc = {(DATA_WIDTH/8){write_data[7:0]}};
            end
            (funct3[1:0] == 2'b01): begin
                be_calc    = 4'b0011 << {alu_result[1], 1'b0};
                wdata_calc = {(DATA_WIDTH/16){write_data[15:0]}};
            end
            funct3[1]: begin
                be_calc    = 4'b1111;
                wdata_calc = write_data;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read data
    always_comb begin
        lane_b   = dmem_rdata[{off_q, 3'b000} +: 8];
        lane_h   = dmem_rdata[{off_q[1], 4'b0000} +: 16];
        load_val = dmem_rdata;
        unique case (1'b1)
            (size_q == 2'b00):
                load_val = {{(DATA_WIDTH-8){lane_b[7] & ~uns_q}}, lane_b};
            (size_q == 2'b01):
                load_val = {{(DATA_WIDTH-16){lane_h[15] & ~uns_q}}, lane_h};
            size_q[1]:
                load_val = dmem_rdata;
        endcase
    end

    // Access FSM with registered bus and writeback outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            o_valid    <= 1'b0;
            mem_result <= '0;
            from_mem   <= '0;
            bus_error  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            o_valid   <= 1'b0;
            bus_error <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        from_mem <= alu_result;
                        if (!is_mem) begin
                            o_valid    <= 1'b1;
                            mem_result <= alu_result;
                        end
`ifdef MISALIGN_TRAP_EN
                        else if (mis) begin
                            misaligned <= 1'b1;
                            o_valid    <= 1'b1;
                            mem_result <= '0;
                            state      <= RESP;
                        end
`endif
                        else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= ctrl_mem_write;
                            dmem_addr  <= {alu_result[DATA_WIDTH-1:2], 2'b00};
                            dmem_be    <= be_calc;
                            dmem_wdata <= wdata_calc;
                            size_q     <= funct3[1:0];
                            uns_q      <= funct3[2];
                            off_q      <= alu_result[1:0];
                            cnt        <= '0;
                            state      <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (dmem_ack) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        mem_result <= load_val;
                        o_valid    <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                            dmem_req   <= 1'b0;
                            dmem_we    <= 1'b0;
                            bus_error  <= 1'b1;
                            mem_result <= '0;
                            o_valid    <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
